// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and byte-mask helper for the dmem access path.
package dmem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
   function automatic logic [3:0] size_mask(input logic [1:0] memw);
      return memw == SZ_BYTE ? 4'h1 : memw == SZ_HALF ? 4'h3 : 4'hF;
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane placement of store data/enables across two words and load extraction/extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  memw,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [63:0] rd64,
   output logic [7:0]  be64,
   output logic [63:0] wd64,
   output logic [31:0] ld
);
   logic [31:0] raw;
   always_comb begin
      be64 = {4'b0, size_mask(memw)} << off;
      wd64 = {32'b0, wdata} << {off, 3'b000};
      raw  = 32'(rd64 >> {off, 3'b000});
      ld   = memw == SZ_BYTE ? {{24{~uns & raw[7]}}, raw[7:0]}
           : memw == SZ_HALF ? {{16{~uns & raw[15]}}, raw[15:0]} : raw;
   end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences core loads/stores onto word-wide dmem, splitting misaligned accesses.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int AW          = 32,
   parameter bit ALLOW_SPLIT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [1:0]    memw,
   input  logic          uns,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic          busy,
   output logic          ack,
   output logic          err,
   output logic [31:0]   rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-3:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ready
);
   state_t state, nxt;
   logic r_we, r_uns, r_err, req_split, r_split;
   logic [1:0] r_memw;
   logic [AW-1:0] r_addr;
   logic [31:0] r_wdata, lo, hi, rdata_q, ld;
   logic [7:0] be64;
   logic [63:0] wd64;
   dmem_lane_align u_align (
      .off(r_addr[1:0]), .memw(r_memw), .uns(r_uns), .wdata(r_wdata),
      .rd64({hi, lo}), .be64(be64), .wd64(wd64), .ld(ld)
   );
   assign req_split = ({1'b0, addr[1:0]} + (memw == SZ_BYTE ? 3'd1 : memw == SZ_HALF ? 3'd2 : 3'd4)) > 3'd4;
   assign r_split   = |be64[7:4];
   always_comb begin
      nxt       = state;
      busy      = state != IDLE;
      ack       = state == DONE;
      err       = ack & r_err;
      mem_req   = state == BEAT0 || state == BEAT1;
      mem_we    = mem_req & r_we;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      rdata     = (ack && !r_we && !r_err) ? ld : rdata_q;
      unique case (state)
         IDLE:  if (req) nxt = (req_split && !ALLOW_SPLIT) ? DONE : BEAT0;
         BEAT0: if (mem_ready) nxt = r_split ? BEAT1 : DONE;
         BEAT1: if (mem_ready) nxt = DONE;
         default: nxt = IDLE;
      endcase
      if (state == BEAT0) begin
         mem_addr  = r_addr[AW-1:2];
         mem_be    = be64[3:0];
         mem_wdata = wd64[31:0];
      end else if (state == BEAT1) begin
         mem_addr  = r_addr[AW-1:2] + (AW-2)'(1);
         mem_be    = be64[7:4];
         mem_wdata = wd64[63:32];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_err   <= 1'b0;
         r_memw  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         lo      <= '0;
         hi      <= '0;
         rdata_q <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && req) begin
            r_we    <= we;
            r_uns   <= uns;
            r_memw  <= memw;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_err   <= req_split && !ALLOW_SPLIT;
         end
         if (state == BEAT0 && mem_ready) lo <= mem_rdata;
         if (state == BEAT1 && mem_ready) hi <= mem_rdata;
         if (ack && !r_we && !r_err) rdata_q <= ld;
      end
   end
endmodule
